// File: rtl/boolean_arb_pkg.sv
// -----------------------------------------------------------------------------
// boolean_arb_pkg
// Shared types and constants for the boolean_arbiter slice.
//   state_t      : output register state (IDLE = nothing held, HOLD = result held)
//   ALUFN_*      : common alufn_sig truth-table codes (fn is passed through as-is)
//   CNT_W        : width of the optional grant counters
// -----------------------------------------------------------------------------
package boolean_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] ALUFN_AND = 4'b1000;
  localparam logic [3:0] ALUFN_XOR = 4'b0110;
  localparam logic [3:0] ALUFN_OR  = 4'b1110;

  localparam int CNT_W = 16;

endpackage

// File: rtl/boolean_arbiter_if.sv
// -----------------------------------------------------------------------------
// boolean_arbiter_if
// Bundles the two request channels and the single response channel.
//   req0_* / req1_* : valid/ready request channels (a, b operands, 4-bit fn)
//   out_*           : valid/ready response channel (data + requester id)
// Modports:
//   master : requester/consumer side (drives requests, accepts responses)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface boolean_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_fn;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_fn;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_fn,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_fn,
    input  req1_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fn,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_fn,
    output req1_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );

endinterface

// File: rtl/boolean_unit.sv
// -----------------------------------------------------------------------------
// boolean_unit
// Bitwise boolean function of two operands selected by a 4-bit truth table.
// For every bit i: y[i] = alufn_sig[{b[i], a[i]}], so 1000 = AND,
// 0110 = XOR, 1110 = OR, 1010 = pass A.
// Ports:
//   a, b      in  WIDTH  operands
//   alufn_sig in  4      truth-table code
//   y         out WIDTH  result (purely combinational)
// -----------------------------------------------------------------------------
module boolean_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alufn_sig,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can infer a latch.
    y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = alufn_sig[{b[i], a[i]}];
    end
  end

endmodule

// File: rtl/boolean_arbiter.sv
// -----------------------------------------------------------------------------
// boolean_arbiter
// Shares one boolean_unit between two requesters with round-robin arbitration.
// A granted request is evaluated in the grant cycle and its result registered
// onto the response channel, tagged with the requester id.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   bus        slave modport of boolean_arbiter_if (requests + response)
//   grant_cnt0 out  saturating handshake count, requester 0 (stats build only)
//   grant_cnt1 out  saturating handshake count, requester 1 (stats build only)
// Configuration:
//   BOOLEAN_ARB_STATS_EN  adds the grant counters; arbitration is unchanged.
// -----------------------------------------------------------------------------
module boolean_arbiter
  import boolean_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  boolean_arbiter_if.slave      bus
`ifdef BOOLEAN_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1
`endif
);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] data_q;
  logic             id_q;

  logic             can_accept;
  logic             grant_any;
  logic             grant_id;
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic [3:0]       mux_fn;
  logic [WIDTH-1:0] unit_y;

  // Grant decision. The output slot is free when nothing is held or the held
  // result leaves this cycle. rst gates the readies because the state register
  // already reads IDLE during reset and would otherwise look free.
  always_comb begin
    can_accept = 1'b0;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    mux_a      = '0;
    mux_b      = '0;
    mux_fn     = '0;

    can_accept = !rst && ((state == IDLE) || bus.out_ready);
    grant_any  = can_accept && (bus.req0_valid || bus.req1_valid);

    // On a tie the requester that did not win last time goes; otherwise the
    // single valid requester wins (req1_valid doubles as its id).
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
    else                                  grant_id = bus.req1_valid;

    if (grant_id) begin
      mux_a  = bus.req1_a;
      mux_b  = bus.req1_b;
      mux_fn = bus.req1_fn;
    end else begin
      mux_a  = bus.req0_a;
      mux_b  = bus.req0_b;
      mux_fn = bus.req0_fn;
    end
  end

  boolean_unit #(.WIDTH(WIDTH)) u_boolean_unit (
    .a         (mux_a),
    .b         (mux_b),
    .alufn_sig (mux_fn),
    .y         (unit_y)
  );

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any &&  grant_id;
  assign bus.out_valid  = (state == HOLD);
  assign bus.out_data   = data_q;
  assign bus.out_id     = id_q;

  // Output FSM. last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only,
      // so every register samples the pre-edge value of every other one.
      case (state)
        IDLE: begin
          if (grant_any) begin
            data_q     <= unit_y;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // grant_any already implies out_ready here, so a grant replaces the
          // departing result back-to-back.
          if (grant_any) begin
            data_q     <= unit_y;
            id_q       <= grant_id;
            last_grant <= grant_id;
          end else if (bus.out_ready) begin
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOLEAN_ARB_STATS_EN
  // Handshake counters, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (bus.req0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (bus.req1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/boolean_arbiter.md
# boolean_arbiter

Shares one `boolean_unit` instance between two independent requesters using a valid/ready handshake and round-robin arbitration. Each accepted request is evaluated in the cycle it is granted. The result is registered and presented on a single response channel tagged with the requester id. The block sits between the decode/execute sequencing logic and the boolean datapath, so two issue sources can use the unit without duplicating it.

## Interface
- `WIDTH`, 32, operand and result width passed to `boolean_unit`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 holds a valid operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_fn`  in  4  requester 0 `alufn_sig` truth-table code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_fn`  are the same as above for requester 1.
- `out_valid`  out  1  registered result is available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  registered `boolean_unit` result.
- `out_id`  out  1  id of the requester that produced `out_data`.
- `grant_cnt0`, `grant_cnt1`  out  16  grant counters, present only with `BOOLEAN_ARB_STATS_EN`.

## Operation
- States: IDLE (no result held) and HOLD (result held, `out_valid`=1).
- "Can accept" = state IDLE, or state HOLD with `out_ready`=1.
- Arbitration happens only when the block can accept:
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester that is not `last_grant`.
  - `last_grant` is updated to the granted id.
- On grant:
  - Assert `reqN_ready`=1 (combinational, same cycle).
  - Mux the granted a/b/fn into `boolean_unit`.
  - Register its output into `out_data` and the id into `out_id`.
  - Go to HOLD.
- HOLD with `out_ready`=1:
  - With a grant: stay in HOLD with the new result (back-to-back).
  - Without a grant: go to IDLE.
- HOLD with `out_ready`=0: `out_data`, `out_id` and `out_valid` are stable, and both `reqN_ready`=0.
- Requesters must hold a/b/fn stable while valid is high and ready is low. The arbiter never drops a valid request.
- `fn` is passed through unmodified; every 4-bit code is legal (e.g. 1000 AND, 0110 XOR, 1110 OR).

## Timing
- Reset values:
  - state=IDLE, `out_valid`=0, `out_data`=0, `out_id`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - `reqN_ready`=0, counters=0.
- Latency: the request handshake in cycle T gives `out_valid`=1 in cycle T+1.
- Throughput: one operation per cycle while `out_ready` stays high.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset asserted mid-operation: any held result is discarded and `out_valid` drops asynchronously. An un-handshaked request stays pending at its requester and is re-arbitrated after reset.
- While `rst`=1 no ready is asserted.

## Configuration
- `BOOLEAN_ARB_STATS_EN` defined:
  - Adds `grant_cnt0` and `grant_cnt1` ports.
  - Each increments by 1 on its requester's handshake and saturates at 16'hFFFF.
  - Both are cleared by `rst`.
- Undefined: the ports and counters do not exist, and arbitration behaviour is identical.

## Structure
- Package `boolean_arb_pkg`:
  - State enum (IDLE, HOLD).
  - `ALUFN_AND`=4'b1000, `ALUFN_XOR`=4'b0110, `ALUFN_OR`=4'b1110.
  - Counter width constant 16.
- Sub-module: one `boolean_unit #(.WIDTH(WIDTH))` instance, fed by the grant mux. No other sub-modules.

## Test plan
- WIDTH=8, after reset only req0 valid with a=8'hF0, b=8'h3C, fn=1000 → `req0_ready` high in the same cycle; next cycle `out_valid`=1, `out_data`=8'h30, `out_id`=0.
- Both valid in the same cycle: req0 XOR 8'hFF/8'h0F, req1 OR 8'h01/8'h02, `out_ready`=1 → req0 granted first (8'hF0, id 0), then req1 the next cycle (8'h03, id 1).
- `out_ready`=0 for 5 cycles with req1 valid → `out_data` and `out_id` stable and `req1_ready`=0 throughout; the cycle `out_ready` rises, req1 is granted.
- Both valid continuously for 8 cycles with `out_ready`=1 → `out_id` sequence 0,1,0,1,0,1,0,1 and `out_valid` held high.
- Assert `rst` while in HOLD → `out_valid` is 0 immediately; after release, a pending req1 is granted first (since `last_grant`=1 and req0 is idle) with the correct result.
- With `BOOLEAN_ARB_STATS_EN`: 3 req0 grants and 2 req1 grants → `grant_cnt0`=3, `grant_cnt1`=2. Force the count to 16'hFFFF and issue one more grant → it stays 16'hFFFF.
